// File: rtl/ecg_deriv_sq_mwi_axis.sv
// ecg_deriv_sq_mwi_axis
// Pan-Tompkins feature stage: 5-point derivative, square/scale, and a
// moving-window integrator over 2^win_log2 samples. It produces a
// non-negative energy envelope for the downstream R-peak detector.
//
// Pipeline: S1 derivative -> S2 square/scale -> S3 MWI + output register.
// Every stage advances on a single global enable (output empty or taken),
// so a stalled output freezes the whole chain.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   s_axis_tdata   signed filtered ECG sample (inout_width bits)
//   s_axis_tvalid  upstream sample valid
//   s_axis_tready  block can accept a sample this cycle (combinational)
//   m_axis_tdata   unsigned MWI output (window sum >> win_log2)
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//
// Build option: define MWI_SQ_SATURATE_EN to saturate the scaled square
// to 2^inout_width-1. Without it, the scaled square is truncated (wraps).
module ecg_deriv_sq_mwi_axis #(
  parameter int inout_width = 16,
  parameter int win_log2    = 6,
  parameter int sq_shift    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [inout_width-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int W  = inout_width;
  localparam int DW = inout_width + 3;
  localparam int PW = 2 * inout_width;
  localparam int N  = 1 << win_log2;
  localparam int SW = inout_width + win_log2;

  // Sign-extend a sample into the derivative accumulator width.
  function automatic logic signed [DW-1:0] sext(input logic [W-1:0] v);
    return {{3{v[W-1]}}, v};
  endfunction

  // Reduce the scaled square to the output width (saturate or wrap).
  function automatic logic [W-1:0] reduce_q(input logic [PW-1:0] v);
    logic [W-1:0] r;
`ifdef MWI_SQ_SATURATE_EN
    if (|v[PW-1:W]) begin
      r = {W{1'b1}};
    end else begin
      r = v[W-1:0];
    end
`else
    r = v[W-1:0];
`endif
    return r;
  endfunction

  logic                    en_s;
  logic                    acc_s;
  logic [W-1:0]            hist_r [4];
  logic signed [DW-1:0]    dsum_s;
  logic signed [DW-1:0]    dsh_s;
  logic signed [W-1:0]     d_r;
  logic                    v1_r;
  logic signed [PW-1:0]    dx_s;
  logic signed [PW-1:0]    prod_s;
  logic [PW-1:0]           sq_s;
  logic [W-1:0]            q_r;
  logic                    v2_r;
  logic [W-1:0]            win_r [N];
  logic [win_log2-1:0]     wp_r;
  logic [SW-1:0]           sum_r;
  logic [SW-1:0]           new_sum_s;
  logic [W-1:0]            tdata_r;
  logic                    tvalid_r;

  assign en_s          = !tvalid_r || m_axis_tready;
  assign acc_s         = s_axis_tvalid && en_s;
  assign s_axis_tready = en_s;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;

  // Derivative of the incoming sample against the history (floor shift).
  always_comb begin
    dsum_s = (sext(s_axis_tdata) <<< 1'b1) + sext(hist_r[0])
           - sext(hist_r[2]) - (sext(hist_r[3]) <<< 1'b1);
    dsh_s  = dsum_s >>> 2'd3;
  end

  // Square of the S1 derivative in full width, then the scaling shift.
  always_comb begin
    dx_s   = {{W{d_r[W-1]}}, d_r};
    prod_s = dx_s * dx_s;
    sq_s   = $unsigned(prod_s) >> sq_shift;
  end

  // Running sum after replacing the oldest window entry with the new one.
  // The sum always holds at least the entry being removed, so it cannot go
  // negative.
  always_comb begin
    new_sum_s = sum_r + {{win_log2{1'b0}}, q_r} - {{win_log2{1'b0}}, win_r[wp_r]};
  end

  // Pipeline, history, window and output registers; all hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_r[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        win_r[i] <= '0;
      end
      d_r      <= '0;
      v1_r     <= 1'b0;
      q_r      <= '0;
      v2_r     <= 1'b0;
      wp_r     <= '0;
      sum_r    <= '0;
      tdata_r  <= '0;
      tvalid_r <= 1'b0;
    end else if (en_s) begin
      if (acc_s) begin
        hist_r[3] <= hist_r[2];
        hist_r[2] <= hist_r[1];
        hist_r[1] <= hist_r[0];
        hist_r[0] <= s_axis_tdata;
        d_r       <= dsh_s[W-1:0];
        v1_r      <= 1'b1;
      end else begin
        v1_r <= 1'b0;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        q_r <= reduce_q(sq_s);
      end
      tvalid_r <= v2_r;
      if (v2_r) begin
        win_r[wp_r] <= q_r;
        sum_r       <= new_sum_s;
        wp_r        <= wp_r + {{(win_log2-1){1'b0}}, 1'b1};
        tdata_r     <= new_sum_s[SW-1:win_log2];
      end
    end
  end

endmodule

// File: tb/tb_ecg_deriv_sq_mwi_axis.sv
// Testbench for ecg_deriv_sq_mwi_axis. An integer reference model produces
// expected outputs into a queue on every accepted sample, and the monitor
// pops and compares them on every output handshake. A second instance with
// sq_shift=4 exercises the saturation/wrap option.
module tb_ecg_deriv_sq_mwi_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  logic [15:0] s2_tdata;
  logic        s2_tvalid;
  logic        s2_tready;
  logic [15:0] m2_tdata;
  logic        m2_tvalid;
  logic        m2_tready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_q[$];
  int ts_q[$];
  int out_log[$];
  int out2_log[$];
  bit lat_chk_en;

  int mh[4];
  int mwin[64];
  int msum;
  int mwp;

`ifdef MWI_SQ_SATURATE_EN
  localparam int SAT_FIRST  = 1023;
  localparam int SAT_SECOND = 2047;
`else
  localparam int SAT_FIRST  = 1008;
  localparam int SAT_SECOND = 2008;
`endif

  ecg_deriv_sq_mwi_axis #(.inout_width(16), .win_log2(6), .sq_shift(14)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  ecg_deriv_sq_mwi_axis #(.inout_width(16), .win_log2(6), .sq_shift(4)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ts_q.delete();
    for (int i = 0; i < 4; i++) mh[i] = 0;
    for (int i = 0; i < 64; i++) mwin[i] = 0;
    msum = 0;
    mwp  = 0;
  endtask

  task automatic model_push(input int x);
    int t;
    int d;
    int q;
    t = 2 * x + mh[0] - mh[2] - 2 * mh[3];
    d = t >>> 3;
    q = (d * d) >> 14;
`ifdef MWI_SQ_SATURATE_EN
    if (q > 65535) q = 65535;
`else
    q = q & 32'h0000_FFFF;
`endif
    msum = msum + q - mwin[mwp];
    mwin[mwp] = q;
    mwp = (mwp + 1) % 64;
    mh[3] = mh[2];
    mh[2] = mh[1];
    mh[1] = mh[0];
    mh[0] = x;
    exp_q.push_back(msum >> 6);
    ts_q.push_back(lat_chk_en ? cyc : -1);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    int e;
    int t;
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_tvalid", {31'd0, m_axis_tvalid}, 0);
        end else begin
          e = exp_q.pop_front();
          t = ts_q.pop_front();
          chk("out_data", {16'd0, m_axis_tdata}, e);
          if (t >= 0) chk("latency", cyc - t, 3);
          out_log.push_back(int'(m_axis_tdata));
        end
      end
      if (s_axis_tvalid && s_axis_tready) model_push(int'($signed(s_axis_tdata)));
    end
  end

  // Output log for the sq_shift=4 instance.
  always @(negedge clk) begin
    if (!rst && m2_tvalid && m2_tready) out2_log.push_back(int'(m2_tdata));
  end

  task automatic send(input logic [15:0] v);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_axis_tready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", {31'd0, s_axis_tready}, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stall5();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd8000;
    repeat (5) begin
      @(negedge clk);
      chk("stall_tready", {31'd0, s_axis_tready}, 0);
      chk("stall_tvalid", {31'd0, m_axis_tvalid}, 1);
      if (exp_q.size() > 0) chk("stall_data", {16'd0, m_axis_tdata}, exp_q[0]);
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nz;
    rst           = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd5000;
    m_axis_tready = 1'b1;
    s2_tvalid     = 1'b0;
    s2_tdata      = 16'd0;
    m2_tready     = 1'b1;
    lat_chk_en    = 1'b1;
    model_reset();

    // Reset held with a valid sample pending: nothing may be consumed.
    repeat (2) begin
      @(negedge clk);
      chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
      chk("rst_tdata", {16'd0, m_axis_tdata}, 0);
      chk("rst_tready", {31'd0, s_axis_tready}, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;

    // Step 0 -> 8000 with a 5-cycle backpressure window inside it.
    out_log.delete();
    for (int i = 0; i < 8; i++) send(16'd0);
    for (int j = 0; j < 80; j++) begin
      if (j == 15) lat_chk_en = 1'b0;
      if (j == 20) stall5();
      send(16'd8000);
    end
    idle(8);
    lat_chk_en = 1'b1;
    chk("step_count", out_log.size(), 88);
    chk("step_pre", out_log[7], 0);
    chk("step_o0", out_log[8], 3);
    chk("step_o1", out_log[9], 12);
    chk("step_o2", out_log[10], 20);
    chk("step_o3", out_log[11], 24);
    chk("step_hold", out_log[71], 24);
    chk("step_d0", out_log[72], 20);
    chk("step_d1", out_log[73], 12);
    chk("step_d2", out_log[74], 3);
    chk("step_d3", out_log[75], 0);

    // Bubbles: valid every other cycle, window wraps several times.
    out_log.delete();
    for (int i = 0; i < 200; i++) begin
      send(16'd1234);
      idle(1);
    end
    idle(8);
    chk("bub_count", out_log.size(), 200);
    chk("bub_settle", out_log[199], 0);
    @(negedge clk);
    chk("idle_tvalid", {31'd0, m_axis_tvalid}, 0);
    @(posedge clk);
    #1;

    // Saturation / wrap on the sq_shift=4 instance.
    out2_log.delete();
    for (int i = 0; i < 12; i++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = (i < 8) ? 16'd0 : 16'd32767;
      @(negedge clk);
      chk("s2_tready", {31'd0, s2_tready}, 1);
      @(posedge clk);
      #1;
    end
    s2_tvalid = 1'b0;
    idle(8);
    chk("sat_count", out2_log.size(), 12);
    chk("sat_pre", out2_log[7], 0);
    chk("sat_first", out2_log[8], SAT_FIRST);
    chk("sat_second", out2_log[9], SAT_SECOND);

    // Reset in the middle of a step, then zeros: everything must be cleared.
    for (int i = 0; i < 10; i++) send(16'd8000);
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd8000;
    model_reset();
    out_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 70; i++) send(16'd0);
    idle(8);
    nz = 0;
    foreach (out_log[i]) if (out_log[i] != 0) nz++;
    chk("mr_count", out_log.size(), 70);
    chk("mr_nonzero", nz, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecg_deriv_sq_mwi_axis.md
Name: ecg_deriv_sq_mwi_axis

Overview:
Pan-Tompkins feature stage that sits directly downstream of the 4th-order bandpass IIR in the ECG chain.
- Consumes band-limited ECG samples on AXI4-Stream.
- Computes the 5-point derivative, squares and scales it, then applies a moving-window integrator (MWI) over a power-of-2 window.
- Emits a non-negative energy envelope on AXI4-Stream for the downstream R-peak detector.

Parameters:
inout_width, 16, input sample / output envelope width in bits
win_log2, 6, MWI window length N = 2^win_log2 samples (64 = 128 ms at 500 Hz)
sq_shift, 14, right shift applied to the squared derivative before integration

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  inout_width  signed filtered ECG sample
s_axis_tvalid  in  1  upstream sample valid
s_axis_tready  out  1  block can accept a sample this cycle
m_axis_tdata  out  inout_width  MWI output, unsigned value, MSB-aligned in the field
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset state: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1.
  - Sample history x[n-1..n-4] cleared to 0.
  - All N window entries cleared to 0; running sum cleared to 0; pipeline valid bits cleared.
- Pipeline: 3 stages (S1 derivative, S2 square/scale, S3 MWI/output register).
  - Each stage has a valid bit.
  - Global advance enable: en = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = en (combinational).
  - Sample accepted when s_axis_tvalid && s_axis_tready.
  - Latency accept→m_axis_tvalid = 3 cycles when unstalled; throughput 1 sample/cycle.
- Stall (en=0): every stage register, history, window and sum hold; m_axis_tdata stable; no sample accepted. Samples are never dropped or duplicated.
- Bubbles: when no sample is accepted while en=1, stage valids shift a 0. History, window and sum update only on valid data.
- S1 derivative: d = (2x[n] + x[n-1] - x[n-3] - 2x[n-4]) >>> 3.
  - Compute in inout_width+3 signed bits; arithmetic shift (floor).
  - The result always fits inout_width signed.
  - History shifts on accept.
- S2 square/scale: q = (d*d) >> sq_shift, unsigned.
  - Reduced to inout_width bits per the optional feature.
- S3 MWI:
  - Circular buffer of N entries, write pointer win_log2 bits, wraps N-1→0.
  - sum <= sum + q - buf[wp]; buf[wp] <= q; wp++.
  - Sum width inout_width+win_log2 unsigned, never overflows.
  - m_axis_tdata = new sum >> win_log2 (floor), registered with m_axis_tvalid.
- Warm-up: outputs during the first 4 samples (partial history) and the first N samples (partial window) are still valid and computed from the zeroed state.
- Reset mid-operation: rst overrides all activity in that cycle. In-flight samples are discarded and everything returns to the reset state on the next edge.

Optional Feature:
Macro MWI_SQ_SATURATE_EN.
- Defined: q saturates to 2^inout_width-1 when (d*d)>>sq_shift exceeds it.
- Undefined: q is truncated to its low inout_width bits (wraps). This is safe only when sq_shift >= 2*inout_width-2-inout_width (default values never exceed the range: max 36861).

Test Plan:
- Reset: hold rst 2 cycles with s_axis_tvalid=1 → m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1; no sample consumed.
- Step: 8 zeros then constant 8000, m_axis_tready=1 → outputs 0 for the zeros, then 3, 12, 20, 24.
  - Output holds 24 until the 64th post-step sample, then 20, 12, 3, 0.
  - Each output arrives 3 cycles after its accept.
- Backpressure: during the step, drop m_axis_tready for 5 cycles → m_axis_tdata/tvalid frozen and s_axis_tready=0 for 5 cycles; after release the output sequence is identical to the unstalled run.
- Bubbles/wrap: 200 samples of 1234 with s_axis_tvalid toggling every other cycle → the output sequence matches the contiguous run; it settles at 0 after the window drains; no spurious tvalid.
- Saturation, sq_shift=4: zeros then 32767 → first q from d=8191.
  - Macro defined: first output 1023 (65535>>6).
  - Macro undefined: first output 1008 (64512>>6).
- Mid-stream reset: assert rst for 1 cycle at step+10 samples, then feed zeros → all outputs 0 (window and sum cleared).
